// File: rtl/popcount_pkg.sv
// Shared types and helpers for the sequenced population counter.
package popcount_pkg;

    localparam int SLICE_W = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_e;

    function automatic int cnt_w(input int data_w);
        return $clog2(data_w + 1);
    endfunction

endpackage

// File: rtl/popcount_sequencer_ones_count3.sv
// Combinational ones-count of a 3-bit slice (0..3).
module ones_count3 (
    input  logic [2:0] i_bits,
    output logic [1:0] o_count
);

    assign o_count = 2'(i_bits[0]) + 2'(i_bits[1]) + 2'(i_bits[2]);

endmodule

// File: rtl/popcount_sequencer.sv
// Streams a word LSB-first through one 3-bit counter and
// accumulates the set-bit total behind valid/ready handshakes.
module popcount_sequencer
    import popcount_pkg::*;
#(
    parameter  int DATA_W = 12,
    localparam int CNT_W  = cnt_w(DATA_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  out_count,
    output logic              busy
);

    localparam int NSLICE = DATA_W / SLICE_W;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    if ((DATA_W % SLICE_W) != 0 || DATA_W < SLICE_W) begin : g_bad_width
        $error("DATA_W must be a positive multiple of 3");
    end

    state_e             r_state;
    logic [DATA_W-1:0]  r_shreg;
    logic [CNT_W-1:0]   r_acc;
    logic [IDX_W-1:0]   r_idx;
    logic [CNT_W-1:0]   r_count;
    logic [1:0]         w_pc;
    logic [CNT_W-1:0]   w_sum;

    ones_count3 u_pc3 (
        .i_bits  (r_shreg[2:0]),
        .o_count (w_pc)
    );

    // Sum never exceeds DATA_W, so CNT_W bits cannot overflow.
    assign w_sum = r_acc + CNT_W'(w_pc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_shreg <= '0;
            r_acc   <= '0;
            r_idx   <= '0;
            r_count <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_shreg <= in_data;
                        r_acc   <= '0;
                        r_idx   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc   <= w_sum;
                    r_shreg <= r_shreg >> SLICE_W;
                    r_idx   <= r_idx + IDX_W'(1);
                    if (r_idx == LAST_IDX) begin
                        r_count <= w_sum;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state == S_RUN) || (r_state == S_DONE);
    assign out_count = r_count;

endmodule

// File: doc/popcount_sequencer.md
Name: popcount_sequencer

Overview:
Sequenced population counter for words wider than the 3-bit ones-count slice. Accepts a DATA_W-bit word over a valid/ready handshake and streams it LSB-first, 3 bits per cycle, through a single 3-bit ones-count sub-module. It accumulates the partial counts and returns the total over a second valid/ready handshake. Sits between a producer of bit-vectors (flag/status words) and any consumer needing the set-bit count; it time-shares one small counter instead of a wide adder tree.

Parameters:
DATA_W, 12, input word width; must be a multiple of 3 and at least 3 (elaboration error otherwise)
NSLICE (localparam), DATA_W/3, number of RUN cycles per word
CNT_W (localparam), $clog2(DATA_W+1), result width (4 for DATA_W=12)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  producer has a word on in_data
in_ready  out  1  block can accept a word
in_data  in  DATA_W  word to count
out_valid  out  1  out_count holds a completed result
out_ready  in  1  consumer accepts the result
out_count  out  CNT_W  number of 1s in the accepted word
busy  out  1  high in RUN or DONE

Behaviour:
- Reset (rst_n low, async, regardless of clock): state=IDLE, in_ready=1, out_valid=0, busy=0, out_count=0, shift register=0, accumulator=0, slice index=0. Any in-flight word is discarded with no result.
- States: IDLE, RUN, DONE (3-state FSM, registered state).
- IDLE: in_ready=1. On an edge with in_valid=1: load shreg<=in_data, acc<=0, idx<=0, go to RUN. in_data is sampled only on this edge; later changes are ignored.
- RUN: in_ready=0, busy=1. Each edge: acc<=acc+pc3(shreg[2:0]), shreg<=shreg>>3, idx<=idx+1. On the edge where idx==NSLICE-1, also load out_count<=acc+pc3(shreg[2:0]) and go to DONE.
- pc3 = the 3-bit ones-count (0..3). acc is CNT_W bits wide. The maximum sum is DATA_W, so no overflow and no saturation logic.
- Latency: out_valid rises exactly NSLICE cycles after the input-handshake edge (4 cycles for DATA_W=12).
- DONE: out_valid=1, out_count stable, in_ready=0. On an edge with out_ready=1, go to IDLE; out_valid drops on that edge. out_count keeps its value until the next result loads.
- Throughput: one word per NSLICE+2 cycles with out_ready tied high. No new word is accepted in the same cycle as result retirement.
- Backpressure: out_ready low holds DONE indefinitely. out_valid and out_count stay constant; in_valid is ignored.
- in_valid while RUN/DONE: ignored, nothing is queued. The producer must hold it until in_ready.
- out_ready while IDLE/RUN: no effect.
- Illegal or unreachable state encoding: return to IDLE on the next edge with out_valid=0.

Decomposition:
- popcount_pkg holds:
  - state enum (IDLE, RUN, DONE)
  - SLICE_W=3
  - function for CNT_W from DATA_W
- One natural sub-module: ones_count3 (pure combinational, 3-bit in, 2-bit count out), instantiated once on shreg[2:0].
- FSM, shift register, accumulator and handshakes stay in popcount_sequencer.

Test Plan:
- Reset, then in_data=12'hFFF with in_valid pulse, out_ready=1 -> out_valid high 4 cycles after the handshake edge, out_count=12, back to IDLE next edge.
- in_data=12'h000 -> out_count=0 after 4 cycles. Then 12'hA5A -> out_count=6. Then 12'h001 -> 1. Then 12'h800 -> 1 (both end slices exercised).
- out_ready held low for 10 cycles in DONE -> out_valid and out_count=6 stable, in_ready=0 throughout. Raise out_ready -> retire on that edge, in_ready=1 next cycle.
- After accepting 12'hFFF, drive in_valid=1 with in_data=12'h000 during RUN -> ignored; result is 12, and 12'h000 is accepted only once IDLE is reached.
- Assert rst_n=0 asynchronously mid-RUN (between edges) -> outputs go to reset values immediately, no out_valid ever appears for that word. Next word counts correctly.
- DATA_W=24 instance, in_data=24'hFFFFFF -> out_count=24 (CNT_W=5) after 8 cycles. Random words against a reference popcount in a scoreboard.
